target_generator: RTL and testbench

Produces the food-target cell coordinates consumed by the snake controller. It also keeps the score count. On each accepted TARGET_REACHED pulse during PLAY, it picks a new in-field, pseudo-random cell from two free-running LFSRs using rejection sampling. Coordinates are in the 160x120 cell grid (4x4-pixel cells). Sits upstream of the snake controller; driven by the master state machine.

---
 rtl/target_generator.sv | 91 +++++++++
 tb/tb_target_generator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/target_generator.sv
// Food-target generator: picks a new in-field cell by rejection sampling two
// free-running LFSRs after each eat, and keeps a saturating score.
module target_generator #(
    parameter int          MaxX         = 159,
    parameter int          MaxY         = 119,
    parameter int          INIT_X       = 40,
    parameter int          INIT_Y       = 30,
    parameter logic [7:0]  SEED_H       = 8'hA5,
    parameter logic [6:0]  SEED_V       = 7'h2B,
    parameter int          SEARCH_LIMIT = 63
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MSM_STATE,
    input  logic       TARGET_REACHED,
    output logic [7:0] TARGET_ADDR_H,
    output logic [6:0] TARGET_ADDR_V,
    output logic       TARGET_VALID,
    output logic [7:0] SCORE
);
    localparam int CLOG = $clog2(SEARCH_LIMIT + 1);
    localparam int CW   = (CLOG > 6) ? CLOG : 6;

    localparam logic [7:0]    MAX_H = 8'(MaxX);
    localparam logic [6:0]    MAX_V = 7'(MaxY);
    localparam logic [7:0]    INI_H = 8'(INIT_X);
    localparam logic [6:0]    INI_V = 7'(INIT_Y);
    localparam logic [CW-1:0] LIMIT = CW'(SEARCH_LIMIT);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t        state;
    logic [7:0]    lfsr_h;
    logic [6:0]    lfsr_v;
    logic [CW-1:0] search_cnt;
    logic          accept;

    // Candidate is the currently registered LFSR pair; it must land in the field
    // and move the target somewhere new.
    assign accept = (lfsr_h >= 8'd1) && (lfsr_h <= MAX_H) &&
                    (lfsr_v >= 7'd1) && (lfsr_v <= MAX_V) &&
                    !((lfsr_h == TARGET_ADDR_H) && (lfsr_v == TARGET_ADDR_V));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lfsr_h <= SEED_H;
            lfsr_v <= SEED_V;
        end else begin
            lfsr_h <= {lfsr_h[6:0], lfsr_h[7] ^ lfsr_h[5] ^ lfsr_h[4] ^ lfsr_h[3]};
            lfsr_v <= {lfsr_v[5:0], lfsr_v[6] ^ lfsr_v[5]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || MSM_STATE == 2'b00) begin
            state         <= IDLE;
            TARGET_ADDR_H <= INI_H;
            TARGET_ADDR_V <= INI_V;
            TARGET_VALID  <= 1'b1;
            SCORE         <= 8'd0;
            search_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MSM_STATE == 2'b01 && TARGET_REACHED) begin
                        state        <= SEARCH;
                        TARGET_VALID <= 1'b0;
                        search_cnt   <= '0;
                        if (SCORE != 8'hFF) SCORE <= SCORE + 8'd1;
                    end
                end
                SEARCH: begin
                    if (accept) begin
                        TARGET_ADDR_H <= lfsr_h;
                        TARGET_ADDR_V <= lfsr_v;
                        TARGET_VALID  <= 1'b1;
                        state         <= IDLE;
                    end else if (search_cnt == LIMIT) begin
                        // Out of attempts: step one cell right, wrapping to column 1.
                        TARGET_ADDR_H <= (TARGET_ADDR_H >= MAX_H) ? 8'd1 : TARGET_ADDR_H + 8'd1;
                        TARGET_VALID  <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        search_cnt <= search_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_target_generator.sv
// Randomized bench for target_generator: a full-size and a tiny-field instance,
// both checked every cycle against a behavioural model, plus literal pins.
module tb_target_generator;
    logic       CLK = 0;
    logic       RESET;
    logic [1:0] msm, msm2;
    logic       tr, tr2;
    logic [7:0] h1, h2, s1, s2;
    logic [6:0] v1, v2;
    logic       val1, val2;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    target_generator dut (
        .CLK(CLK), .RESET(RESET), .MSM_STATE(msm), .TARGET_REACHED(tr),
        .TARGET_ADDR_H(h1), .TARGET_ADDR_V(v1), .TARGET_VALID(val1), .SCORE(s1)
    );

    target_generator #(.MaxX(4), .MaxY(4), .INIT_X(4), .INIT_Y(2), .SEARCH_LIMIT(0)) dut2 (
        .CLK(CLK), .RESET(RESET), .MSM_STATE(msm2), .TARGET_REACHED(tr2),
        .TARGET_ADDR_H(h2), .TARGET_ADDR_V(v2), .TARGET_VALID(val2), .SCORE(s2)
    );

    typedef struct packed {
        int h; int v; int lh; int lv; int valid; int score; int srch; int cnt;
    } mdl_t;

    mdl_t m1, m2;
    bit   m_ok = 0;

    // Cycle model written directly from the behavioural rules.
    function automatic mdl_t mstep(mdl_t m, bit rst, logic [1:0] st, bit pulse,
                                   int mx, int my, int ix, int iy, int lim);
        mdl_t n = m;
        if (rst) begin
            n.h = ix; n.v = iy; n.lh = 'hA5; n.lv = 'h2B;
            n.valid = 1; n.score = 0; n.srch = 0; n.cnt = 0;
            return n;
        end
        n.lh = ((m.lh << 1) & 255) | (((m.lh >> 7) ^ (m.lh >> 5) ^ (m.lh >> 4) ^ (m.lh >> 3)) & 1);
        n.lv = ((m.lv << 1) & 127) | (((m.lv >> 6) ^ (m.lv >> 5)) & 1);
        if (st == 2'b00) begin
            n.h = ix; n.v = iy; n.valid = 1; n.score = 0; n.srch = 0; n.cnt = 0;
        end else if (m.srch == 0) begin
            if (st == 2'b01 && pulse) begin
                n.srch = 1; n.valid = 0; n.cnt = 0;
                n.score = (m.score < 255) ? m.score + 1 : 255;
            end
        end else if (m.lh >= 1 && m.lh <= mx && m.lv >= 1 && m.lv <= my &&
                     !(m.lh == m.h && m.lv == m.v)) begin
            n.h = m.lh; n.v = m.lv; n.valid = 1; n.srch = 0;
        end else if (m.cnt == lim) begin
            n.h = (m.h >= mx) ? 1 : m.h + 1; n.valid = 1; n.srch = 0;
        end else begin
            n.cnt = m.cnt + 1;
        end
        return n;
    endfunction

    always @(posedge CLK) begin
        m1   <= mstep(m1, RESET, msm, tr, 159, 119, 40, 30, 63);
        m2   <= mstep(m2, RESET, msm2, tr2, 4, 4, 4, 2, 0);
        m_ok <= m_ok | RESET;
    end

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (m_ok) begin
            tests++;
            if (h1 != m1.h[7:0] || v1 != m1.v[6:0] || val1 != m1.valid[0] || s1 != m1.score[7:0]) begin
                fails++;
                $display("FAIL model_main @%0t: got h=%0d v=%0d valid=%0d score=%0d expected h=%0d v=%0d valid=%0d score=%0d",
                         $time, h1, v1, val1, s1, m1.h, m1.v, m1.valid, m1.score);
            end
            tests++;
            if (h2 != m2.h[7:0] || v2 != m2.v[6:0] || val2 != m2.valid[0] || s2 != m2.score[7:0]) begin
                fails++;
                $display("FAIL model_small @%0t: got h=%0d v=%0d valid=%0d score=%0d expected h=%0d v=%0d valid=%0d score=%0d",
                         $time, h2, v2, val2, s2, m2.h, m2.v, m2.valid, m2.score);
            end
        end
    end

    task automatic pulse1();
        tr = 1; @(negedge CLK); tr = 0;
    endtask

    task automatic wait_valid(string name);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (val1) begin ok = 1; break; end
            @(negedge CLK);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: valid=%0d expected 1 within 100 cycles", name, val1);
        end
    endtask

    task automatic wait_valid2(string name);
        bit ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (val2) begin ok = 1; break; end
            @(negedge CLK);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: valid=%0d expected 1 within 10 cycles", name, val2);
        end
    endtask

    initial begin
        int ph, pv, ps;
        RESET = 1; msm = 2'b01; tr = 0; msm2 = 2'b01; tr2 = 0;

        // Reset
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 0;
        chk("reset_h", h1, 40);
        chk("reset_v", v1, 30);
        chk("reset_valid", val1, 1);
        chk("reset_score", s1, 0);
        chk("reset_lfsr_h", dut.lfsr_h, 'hA5);
        chk("reset_lfsr_v", dut.lfsr_v, 'h2B);
        chk("reset_small_h", h2, 4);
        chk("reset_small_v", v2, 2);

        // Single eat
        repeat ($urandom_range(1, 5)) @(negedge CLK);
        pulse1();
        chk("eat_valid_low", val1, 0);
        chk("eat_score", s1, 1);
        wait_valid("eat_settle");
        chk("eat_h_range", int'(h1 >= 1 && h1 <= 159), 1);
        chk("eat_v_range", int'(v1 >= 1 && v1 <= 119), 1);
        chk("eat_moved", int'(h1 != 40 || v1 != 30), 1);

        // Pulse storm: every other cycle for 20 cycles
        for (int i = 0; i < 10; i++) begin
            tr = 1; @(negedge CLK);
            tr = 0; @(negedge CLK);
        end
        wait_valid("storm_settle");

        // Random eats with random gaps
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge CLK);
            tr = 1'($urandom_range(0, 1));
            @(negedge CLK);
            tr = 0;
            wait_valid("rand_settle");
        end

        // LOST freezes target and score
        ph = m1.h; pv = m1.v; ps = m1.score;
        msm = 2'b10;
        for (int i = 0; i < 4; i++) begin pulse1(); @(negedge CLK); end
        msm = 2'b11;
        pulse1();
        chk("lost_h", h1, ph);
        chk("lost_v", v1, pv);
        chk("lost_score", s1, ps);
        msm = 2'b00;
        @(negedge CLK);
        msm = 2'b01;
        chk("start_h", h1, 40);
        chk("start_v", v1, 30);
        chk("start_score", s1, 0);
        chk("start_valid", val1, 1);

        // START beats a simultaneous pulse
        msm = 2'b00; tr = 1;
        @(negedge CLK);
        msm = 2'b01; tr = 0;
        chk("start_vs_pulse_score", s1, 0);

        // Tiny field with immediate fallback
        for (int k = 0; k < 8; k++) begin
            ph = h2; pv = v2;
            tr2 = 1; @(negedge CLK); tr2 = 0;
            @(negedge CLK);
            wait_valid2("small_settle");
            chk("small_range", int'(h2 >= 1 && h2 <= 4 && v2 >= 1 && v2 <= 4), 1);
            if (k == 0)
                chk("small_first", int'((h2 == 1 && v2 == 2) || !(h2 == 4 && v2 == 2)), 1);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        // Saturation
        for (int i = 0; i < 260; i++) begin
            pulse1();
            wait_valid("sat_settle");
        end
        chk("sat_score", s1, 255);

        // Reset in the first SEARCH cycle
        pulse1();
        RESET = 1;
        @(negedge CLK);
        RESET = 0;
        chk("midreset_h", h1, 40);
        chk("midreset_v", v1, 30);
        chk("midreset_valid", val1, 1);
        chk("midreset_score", s1, 0);
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
